// File: rtl/shift_add_ctrl.sv
// shift_add_ctrl: sequential shift-and-add unsigned multiplier controller/datapath.
// Wraps an external partial-product mux: pp_sel selects mcand (in1) or zero (in2),
// and the mux output returns on pp. A product is produced every WL iterations.
//
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   start    - multiply request, sampled only in IDLE
//   a, b     - multiplicand / multiplier (WL bits, unsigned), captured on accept
//   pp       - partial product returned from the external mux
//   pp_sel   - mux select, multiplier register bit 0
//   mcand    - registered multiplicand, drives mux in1
//   busy     - high in RUN and DONE
//   done     - one-cycle pulse, product valid in that cycle
//   product  - last completed result (2*WL bits), held until next completion
module shift_add_ctrl #(
  parameter int unsigned WL = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WL-1:0]     a,
  input  logic [WL-1:0]     b,
  input  logic [WL-1:0]     pp,
  output logic              pp_sel,
  output logic [WL-1:0]     mcand,
  output logic              busy,
  output logic              done,
  output logic [2*WL-1:0]   product
);

  localparam int unsigned PW = 2 * WL;
  localparam int unsigned AW = 2 * WL + 1;
  localparam int unsigned CW = $clog2(WL) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_d;
  logic [AW-1:0]     acc, acc_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [WL-1:0]     mcand_d;
  logic [PW-1:0]     product_d;
  logic              busy_d, done_d;
  logic [WL:0]       sum;
  logic              last_iter;

  // Multiplier LSB lives at acc[0] and is shifted out one bit per iteration.
  assign pp_sel    = acc[0];
  assign last_iter = (cnt == CW'(WL - 1));

  // Next-state and datapath update.
  always_comb begin
    state_d   = state;
    acc_d     = acc;
    cnt_d     = cnt;
    mcand_d   = mcand;
    product_d = product;
    sum       = {1'b0, acc[PW-1:WL]} + {1'b0, pp};

    case (state)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          mcand_d = a;
          acc_d   = {{(WL + 1){1'b0}}, b};
          cnt_d   = '0;
        end
      end
      RUN: begin
        // {0, sum, lo} >> 1 : carry lands in hi MSB, consumed multiplier bit drops out.
        acc_d = {1'b0, sum, acc[WL-1:1]};
        cnt_d = cnt + CW'(1);
        if (last_iter) begin
          state_d   = DONE;
          product_d = acc_d[PW-1:0];
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      mcand   <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_d;
      acc     <= acc_d;
      cnt     <= cnt_d;
      mcand   <= mcand_d;
      product <= product_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_shift_add_ctrl.sv
// Testbench for shift_add_ctrl (WL=4) with a behavioural partial-product mux in the loop.
module tb_shift_add_ctrl;

  localparam int unsigned WL = 4;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [WL-1:0]   a;
  logic [WL-1:0]   b;
  logic [WL-1:0]   pp;
  logic            pp_sel;
  logic [WL-1:0]   mcand;
  logic            busy;
  logic            done;
  logic [2*WL-1:0] product;

  shift_add_ctrl #(.WL(WL)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .pp      (pp),
    .pp_sel  (pp_sel),
    .mcand   (mcand),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  // External 2:1 mux: in1 = mcand, in2 = 0.
  assign pp = pp_sel ? mcand : '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WL-1:0]   a;
    logic [WL-1:0]   b;
    logic [2*WL-1:0] exp;
  } vec_t;

  int unsigned     checks;
  int unsigned     failures;
  int unsigned     done_cnt;
  logic [2*WL-1:0] exp_q[$];
  logic [WL-1:0]   m_sr;
  vec_t            vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Negedge observer: scoreboard pop on done, pp_sel vs multiplier bit every RUN cycle.
  task automatic monitor();
    logic [2*WL-1:0] e;
    if (!rst_n) return;
    if (done === 1'b1) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got product %0d expected no done at %0t", product, $time);
      end else begin
        e = exp_q.pop_front();
        chk("product", 32'(product), 32'(e));
      end
    end
    if (busy === 1'b1 && done !== 1'b1) begin
      chk("pp_sel", 32'(pp_sel), 32'(m_sr[0]));
      m_sr = m_sr >> 1;
    end
    if (busy === 1'b0 && start === 1'b1) m_sr = b;
  endtask

  // One clock: observe at negedge, return 1 time unit after the next rising edge.
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle start, operands scrambled during RUN, latency/busy/hold checks.
  task automatic do_mult(input logic [WL-1:0] va, input logic [WL-1:0] vb,
                         input logic [2*WL-1:0] exp);
    int lat;
    int busy_cyc;
    start = 1'b1;
    a     = va;
    b     = vb;
    exp_q.push_back(exp);
    tick();
    start    = 1'b0;
    a        = WL'($urandom);
    b        = WL'($urandom);
    lat      = 1;
    busy_cyc = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) busy_cyc++;
      tick();
      lat++;
    end
    if (busy === 1'b1) busy_cyc++;
    chk("latency", 32'(lat), 32'(WL + 1));
    chk("busy_cycles", 32'(busy_cyc), 32'(WL + 1));
    tick();
    chk("busy_fall", 32'(busy), 32'(0));
    chk("product_hold", 32'(product), 32'(exp));
  endtask

  initial begin
    int d0;
    int t1;
    int t2;
    checks   = 0;
    failures = 0;
    done_cnt = 0;
    m_sr     = '0;
    rst_n    = 1'b0;
    start    = 1'b0;
    a        = '0;
    b        = '0;

    vecs[0] = '{a: 4'd13, b: 4'd11, exp: 8'd143};
    vecs[1] = '{a: 4'd15, b: 4'd15, exp: 8'd225};
    vecs[2] = '{a: 4'd0,  b: 4'd15, exp: 8'd0};
    vecs[3] = '{a: 4'd15, b: 4'd0,  exp: 8'd0};
    vecs[4] = '{a: 4'd1,  b: 4'd1,  exp: 8'd1};
    vecs[5] = '{a: 4'd9,  b: 4'd7,  exp: 8'd63};

    // Reset state
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_product", 32'(product), 32'(0));
    chk("rst_pp_sel", 32'(pp_sel), 32'(0));
    chk("rst_mcand", 32'(mcand), 32'(0));
    rst_n = 1'b1;

    // Table-driven basic and extreme operands
    for (int i = 0; i < 6; i++) do_mult(vecs[i].a, vecs[i].b, vecs[i].exp);

    // Ignored start during RUN
    d0    = done_cnt;
    start = 1'b1; a = 4'd3; b = 4'd5;
    exp_q.push_back(8'd15);
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; a = 4'd7; b = 4'd7;
    tick();
    start = 1'b0;
    repeat (12) tick();
    chk("ignored_start_dones", 32'(done_cnt - d0), 32'(1));
    chk("ignored_start_product", 32'(product), 32'(15));

    // Back-to-back with start held high
    d0    = done_cnt;
    t1    = -1;
    t2    = -1;
    start = 1'b1; a = 4'd6; b = 4'd7;
    exp_q.push_back(8'd42);
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 1) begin
        a = 4'd2; b = 4'd3;
        exp_q.push_back(8'd6);
      end
      if (i == 7) start = 1'b0;
      if (done === 1'b1) begin
        if (t1 < 0) t1 = i;
        else if (t2 < 0) t2 = i;
      end
    end
    repeat (4) tick();
    chk("b2b_dones", 32'(done_cnt - d0), 32'(2));
    chk("b2b_spacing", 32'(t2 - t1), 32'(WL + 2));
    chk("b2b_last_product", 32'(product), 32'(6));

    // Reset mid-run: aborts with no done, product cleared
    start = 1'b1; a = 4'd9; b = 4'd7;
    exp_q.push_back(8'd63);
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_done", 32'(done), 32'(0));
    chk("midrst_product", 32'(product), 32'(0));
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (10) tick();
    chk("midrst_no_done", 32'(done_cnt - d0), 32'(0));
    chk("midrst_busy_after", 32'(busy), 32'(0));

    // Exhaustive operand sweep against a*b
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        do_mult(WL'(ia), WL'(ib), 8'(ia * ib));
      end
    end

    repeat (3) tick();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
